// File: rtl/draw_rect_pkg.sv
// Shared definitions for the rectangle pipeline: state encoding and screen geometry.
package draw_rect_pkg;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        LANDED = 2'd2,
        BOUNCE = 2'd3
    } state_t;

    localparam int unsigned SCREEN_H_DEF = 768;
    localparam int unsigned SCREEN_W_DEF = 1024;
    // Rectangle height, shared with draw_rect.
    localparam int unsigned RECT_H_DEF   = 64;

endpackage

// File: rtl/rect_fall_ctl_if.sv
// Mouse-in / rectangle-position-out bundle for rect_fall_ctl.
interface rect_fall_ctl_if;

    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;

    modport master (
        output mouse_xpos, mouse_ypos, mouse_left,
        input  xpos, ypos, busy
    );

    modport slave (
        input  mouse_xpos, mouse_ypos, mouse_left,
        output xpos, ypos, busy
    );

endinterface

// File: rtl/tick_gen.sv
// Motion-update tick: pulses for one cycle every TICK_DIV enabled cycles.
module tick_gen #(
    parameter int unsigned TICK_DIV = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    // Counter 0..TICK_DIV-1; clear takes priority so a fresh motion phase starts at zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/rect_fall_ctl.sv
// Rectangle follows the mouse; a click drops it under constant acceleration to the bottom.
// Optional bounce on landing when RECT_BOUNCE_EN is defined.
module rect_fall_ctl
    import draw_rect_pkg::*;
#(
    parameter int unsigned TICK_DIV = 650000,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned VMAX     = 63,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF,
    parameter int unsigned RECT_H   = RECT_H_DEF
) (
    input  logic            pclk,
    input  logic            rst,
    rect_fall_ctl_if.slave  bus
);

    localparam logic [11:0] YMAX  = 12'(SCREEN_H - RECT_H);
    localparam logic [6:0]  GRAV7 = 7'(GRAVITY);
    localparam logic [5:0]  VLIM  = 6'(VMAX);

    state_t      state_q, state_d;
    logic [5:0]  vel_q, vel_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        busy_q, busy_d;
    logic        left_q;
    logic        press;
    logic        tick;
    logic        tick_clr;
    logic        tick_en;
    logic [11:0] y_clamp;
    logic [6:0]  vel_inc;
    logic [5:0]  vel_n;
    logic [12:0] y_sum;

`ifdef RECT_BOUNCE_EN
    localparam logic [7:0] GRAV2 = 8'(2 * GRAVITY);
    localparam logic [5:0] GRAV6 = 6'(GRAVITY);
    logic [5:0] vel_dec;
    assign vel_dec = (vel_q > GRAV6) ? vel_q - GRAV6 : '0;
`endif

    assign press   = bus.mouse_left & ~left_q;
    assign y_clamp = (bus.mouse_ypos > YMAX) ? YMAX : bus.mouse_ypos;
    assign vel_inc = {1'b0, vel_q} + GRAV7;
    assign vel_n   = (vel_inc > {1'b0, VLIM}) ? VLIM : vel_inc[5:0];
    // 13-bit sum so a large velocity near the bottom cannot wrap past YMAX.
    assign y_sum   = {1'b0, ypos_q} + {7'b0, vel_n};
    assign tick_en = (state_q == FALL) || (state_q == BOUNCE);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (pclk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    // Next-state and motion update.
    always_comb begin
        state_d  = state_q;
        vel_d    = vel_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        busy_d   = busy_q;
        tick_clr = 1'b0;
        unique case (state_q)
            FOLLOW: begin
                xpos_d = bus.mouse_xpos;
                ypos_d = y_clamp;
                if (press) begin
                    state_d  = FALL;
                    vel_d    = '0;
                    busy_d   = 1'b1;
                    tick_clr = 1'b1;
                end
            end
            FALL: begin
                if (tick) begin
                    if (y_sum >= {1'b0, YMAX}) begin
                        ypos_d = YMAX;
`ifdef RECT_BOUNCE_EN
                        if ({2'b0, vel_n} >= GRAV2) begin
                            vel_d    = {1'b0, vel_n[5:1]};
                            state_d  = BOUNCE;
                            tick_clr = 1'b1;
                        end else begin
                            state_d = LANDED;
                            busy_d  = 1'b0;
                        end
`else
                        state_d = LANDED;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        ypos_d = y_sum[11:0];
                        vel_d  = vel_n;
                    end
                end
            end
            LANDED: begin
                if (press) begin
                    state_d = FOLLOW;
                end
            end
            default: begin
`ifdef RECT_BOUNCE_EN
                if (tick) begin
                    ypos_d = (ypos_q >= {6'b0, vel_q}) ? ypos_q - {6'b0, vel_q} : '0;
                    vel_d  = vel_dec;
                    if (vel_dec == '0) begin
                        state_d  = FALL;
                        tick_clr = 1'b1;
                    end
                end
`else
                state_d = FOLLOW;
                busy_d  = 1'b0;
`endif
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= FOLLOW;
            vel_q   <= '0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            busy_q  <= 1'b0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vel_q   <= vel_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            busy_q  <= busy_d;
            left_q  <= bus.mouse_left;
        end
    end

    assign bus.xpos = xpos_q;
    assign bus.ypos = ypos_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_rect_fall_ctl.sv
// Randomised scoreboard bench for rect_fall_ctl with a behavioural motion model.
module tb_rect_fall_ctl;
    import draw_rect_pkg::*;

    localparam int TD = 4;
    localparam int G  = 1;
    localparam int VM = 63;
    localparam int SH = 768;
    localparam int RH = 64;
    localparam int YM = SH - RH;
`ifdef RECT_BOUNCE_EN
    localparam bit BOUNCE_ON = 1'b1;
`else
    localparam bit BOUNCE_ON = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int busy;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    always #5 pclk = ~pclk;

    rect_fall_ctl_if bus ();

    rect_fall_ctl #(
        .TICK_DIV (TD),
        .GRAVITY  (G),
        .VMAX     (VM),
        .SCREEN_H (SH),
        .RECT_H   (RH)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: 0 follow, 1 falling, 2 resting, 3 bouncing up.
    int m_mode = 0, m_x = 0, m_y = 0, m_vel = 0, m_age = 0, m_left = 0, m_busy = 0;

    task automatic model_update(input int mx, input int my, input int ml, input int r);
        int press, tick, vn;
        if (r != 0) begin
            m_mode = 0; m_x = 0; m_y = 0; m_vel = 0; m_age = 0; m_left = 0; m_busy = 0;
            return;
        end
        press  = (ml != 0 && m_left == 0) ? 1 : 0;
        m_left = ml;
        tick   = 0;
        if (m_mode == 1 || m_mode == 3) begin
            // A tick closes every group of TD cycles spent in motion.
            tick  = (m_age == TD - 1) ? 1 : 0;
            m_age = (m_age + 1) % TD;
        end
        case (m_mode)
            0: begin
                m_x = mx;
                m_y = (my > YM) ? YM : my;
                if (press != 0) begin
                    m_mode = 1; m_vel = 0; m_age = 0; m_busy = 1;
                end
            end
            1: if (tick != 0) begin
                vn = (m_vel + G > VM) ? VM : m_vel + G;
                if (m_y + vn >= YM) begin
                    m_y = YM;
                    if (BOUNCE_ON && vn >= 2 * G) begin
                        m_vel = vn / 2; m_mode = 3; m_age = 0;
                    end else begin
                        m_mode = 2; m_busy = 0;
                    end
                end else begin
                    m_y   = m_y + vn;
                    m_vel = vn;
                end
            end
            2: if (press != 0) m_mode = 0;
            default: if (tick != 0) begin
                m_y   = (m_y > m_vel) ? m_y - m_vel : 0;
                m_vel = (m_vel > G) ? m_vel - G : 0;
                if (m_vel == 0) begin
                    m_mode = 1; m_age = 0;
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs, record the expected registered outputs after the edge.
    task automatic step(input int mx, input int my, input int ml, input int r);
        exp_t e;
        bus.mouse_xpos = 12'(mx);
        bus.mouse_ypos = 12'(my);
        bus.mouse_left = (ml != 0);
        rst            = (r != 0);
        model_update(mx, my, ml, r);
        e.x = m_x; e.y = m_y; e.busy = m_busy;
        sb_q.push_back(e);
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n, input int mx, input int my, input int ml);
        for (int i = 0; i < n; i++) step(mx, my, ml, 0);
    endtask

    // Directed check against fixed values from the motion rules.
    task automatic expect_now(input string name, input int x, input int y, input int b);
        n_checks++;
        if (bus.xpos !== 12'(x) || bus.ypos !== 12'(y) || bus.busy !== (b != 0)) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d busy=%0b, want x=%0d y=%0d busy=%0d",
                     name, bus.xpos, bus.ypos, bus.busy, x, y, b);
        end
    endtask

    // Monitor: every cycle the outputs are compared with the oldest scoreboard entry.
    always @(negedge pclk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if (bus.xpos !== 12'(mon_e.x) || bus.ypos !== 12'(mon_e.y) ||
                bus.busy !== (mon_e.busy != 0)) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got x=%0d y=%0d busy=%0b, want x=%0d y=%0d busy=%0d",
                         $time, bus.xpos, bus.ypos, bus.busy, mon_e.x, mon_e.y, mon_e.busy);
            end
        end
    end

    initial begin
        int mx, my, ml;
        // Reset held with the mouse elsewhere.
        for (int i = 0; i < 3; i++) begin
            step(300, 400, 0, 1);
            expect_now("reset", 0, 0, 0);
        end
        step(300, 400, 0, 0);
        expect_now("follow_after_reset", 300, 400, 0);
        step(100, 800, 0, 0);
        expect_now("follow_clamp", 100, YM, 0);

        // Fall from y=200.
        step(100, 200, 0, 0);
        step(100, 200, 1, 0);
        expect_now("press_busy", 100, 200, 1);
        idle(4, 100, 200, 1);
        expect_now("tick1", 100, 201, 1);
        idle(4, 500, 10, 0);
        expect_now("tick2", 100, 203, 1);
        idle(4, 500, 10, 0);
        expect_now("tick3", 100, 206, 1);
        idle(4, 500, 10, 0);
        expect_now("tick4", 100, 210, 1);
        idle(250, 500, 10, 0);
        expect_now("landed", 100, YM, 0);

        // Click while resting returns to follow; outputs track one cycle later.
        step(50, 60, 1, 0);
        expect_now("landed_press_hold", 100, YM, 0);
        step(50, 60, 1, 0);
        expect_now("landed_to_follow", 50, 60, 0);

        // Short fall from y=700 with a stray click mid-fall.
        step(100, 700, 0, 0);
        step(100, 700, 1, 0);
        expect_now("press_700", 100, 700, 1);
        step(100, 700, 0, 0); step(100, 700, 1, 0); step(100, 700, 0, 0); step(9, 9, 0, 0);
        expect_now("fall_701", 100, 701, 1);
        idle(4, 9, 9, 0);
        expect_now("fall_703", 100, 703, 1);
        idle(4, 9, 9, 0);
`ifdef RECT_BOUNCE_EN
        expect_now("land_704_bounce", 100, YM, 1);
`else
        expect_now("land_704", 100, YM, 0);
`endif
        idle(30, 9, 9, 0);
        step(50, 60, 0, 0);
        step(50, 60, 1, 0);
        step(50, 60, 0, 0);
        expect_now("refollow", 50, 60, 0);

        // Reset in the middle of a fall.
        step(100, 200, 0, 0);
        step(100, 200, 1, 0);
        idle(12, 100, 200, 0);
        expect_now("pre_reset_206", 100, 206, 1);
        step(100, 200, 0, 1);
        expect_now("reset_mid_fall", 0, 0, 0);

`ifdef RECT_BOUNCE_EN
        step(100, 694, 0, 0);
        step(100, 694, 1, 0);
        idle(12, 100, 694, 0);
        expect_now("b_700", 100, 700, 1);
        idle(4, 100, 694, 0);
        expect_now("b_land", 100, YM, 1);
        idle(4, 100, 694, 0);
        expect_now("b_up1", 100, 702, 1);
        idle(4, 100, 694, 0);
        expect_now("b_up2", 100, 701, 1);
`endif

        // Random traffic.
        mx = 0; my = 0; ml = 0;
        for (int i = 0; i < 4000; i++) begin
            mx = $urandom_range(SCREEN_W_DEF - 1);
            my = $urandom_range(1023);
            if ($urandom_range(19) == 0) ml = 1 - ml;
            step(mx, my, ml, ($urandom_range(599) == 0) ? 1 : 0);
        end

        idle(2, 0, 0, 0);
        @(negedge pclk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
